// File: rtl/noc_packet_loopback.sv
// Store-and-forward NoC packet reflector: buffers one packet, swaps dest/src, replays it.
// Optional header swap is compiled in with NOC_LOOPBACK_SWAP_EN.
module noc_packet_loopback #(
    parameter int FLIT_WIDTH  = 32,
    parameter int DEST_WIDTH  = 5,
    parameter int CLASS_WIDTH = 3,
    parameter int MAX_PKT_LEN = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FLIT_WIDTH-1:0] in_flit,
    input  logic                  in_last,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [FLIT_WIDTH-1:0] out_flit,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [15:0]           pkt_count,
    output logic [15:0]           drop_count
);
    localparam int PTR_W  = (MAX_PKT_LEN > 1) ? $clog2(MAX_PKT_LEN) : 1;
    localparam int LEN_W  = $clog2(MAX_PKT_LEN + 1);
    localparam int SRC_HI = FLIT_WIDTH - DEST_WIDTH - CLASS_WIDTH - 1;

    typedef enum logic [1:0] {RECV, SEND, DROP} state_t;

    state_t                  state;
    logic [FLIT_WIDTH-1:0]   pkt_buf [MAX_PKT_LEN];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [LEN_W-1:0]        pkt_len;
    logic [FLIT_WIDTH-1:0]   rd_word;
    logic                    in_hs;

    assign in_hs = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (!rst && state == RECV && in_hs)
            pkt_buf[wr_ptr] <= in_flit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RECV;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            pkt_len    <= '0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            pkt_count  <= '0;
            drop_count <= '0;
        end else begin
            case (state)
                RECV: begin
                    in_ready <= 1'b1;
                    if (in_hs) begin
                        if (in_last) begin
                            pkt_len   <= LEN_W'(wr_ptr) + LEN_W'(1);
                            rd_ptr    <= '0;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            out_last  <= (wr_ptr == '0);
                            state     <= SEND;
                        end else if (wr_ptr == PTR_W'(MAX_PKT_LEN - 1)) begin
                            // Packet cannot fit; swallow the rest until its last flit.
                            wr_ptr <= '0;
                            state  <= DROP;
                        end else begin
                            wr_ptr <= wr_ptr + 1'b1;
                        end
                    end
                end
                DROP: begin
                    in_ready <= 1'b1;
                    if (in_hs && in_last) begin
                        drop_count <= drop_count + 16'd1;
                        wr_ptr     <= '0;
                        state      <= RECV;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (out_last) begin
                            pkt_count <= pkt_count + 16'd1;
                            rd_ptr    <= '0;
                            wr_ptr    <= '0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            in_ready  <= 1'b1;
                            state     <= RECV;
                        end else begin
                            rd_ptr   <= rd_ptr + 1'b1;
                            out_last <= (int'(rd_ptr) + 2 == int'(pkt_len));
                        end
                    end
                end
                default: state <= RECV;
            endcase
        end
    end

    always_comb begin
        rd_word = pkt_buf[rd_ptr];
`ifdef NOC_LOOPBACK_SWAP_EN
        if (rd_ptr == '0) begin
            rd_word[FLIT_WIDTH-1 -: DEST_WIDTH] = pkt_buf[rd_ptr][SRC_HI -: DEST_WIDTH];
            rd_word[SRC_HI -: DEST_WIDTH]       = pkt_buf[rd_ptr][FLIT_WIDTH-1 -: DEST_WIDTH];
        end
`endif
        // Drive zero when idle so stale buffer contents never leak out.
        out_flit = out_valid ? rd_word : '0;
    end
endmodule

// File: doc/noc_packet_loopback.md
# noc_packet_loopback

Store-and-forward NoC packet reflector that sits directly downstream of a compute tile's NoC output (`noc_out_*`) and feeds its NoC input (`noc_in_*`). It lets a single-tile system exchange message-passing and DMA traffic with itself. The block instantiates one channel; tile-level integration instantiates it once per NoC channel. A complete packet is buffered, the header's destination and source fields are swapped so the packet returns to its sender, and the packet is replayed.

## Interface
Parameters:
- `FLIT_WIDTH`, 32: flit width in bits.
- `DEST_WIDTH`, 5: header destination field width, at bits [FLIT_WIDTH-1 -: DEST_WIDTH].
- `CLASS_WIDTH`, 3: class field width, placed directly below the destination field; never modified.
- `MAX_PKT_LEN`, 8: buffer depth in flits, ≥1. Longer packets are dropped.

Ports:
- `clk`  in  1  system clock. One clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_flit`  in  FLIT_WIDTH  flit from the tile's `noc_out_flit`.
- `in_last`  in  1  last flit of the packet.
- `in_valid`  in  1  input flit valid.
- `in_ready`  out  1  input accept.
- `out_flit`  out  FLIT_WIDTH  flit to the tile's `noc_in_flit`.
- `out_last`  out  1  last flit of the replayed packet.
- `out_valid`  out  1  output flit valid.
- `out_ready`  in  1  tile accepts the output flit.
- `pkt_count`  out  16  packets fully replayed; wraps.
- `drop_count`  out  16  oversize packets discarded; wraps.

## Operation
- States: RECV, SEND, DROP. Reset state is RECV.
- Reset clears the write and read pointers, the stored length and both counters.
- Output values during reset: `in_ready`=0, `out_valid`=0, `out_last`=0, `out_flit`=0, counters=0.
- Reset mid-operation: any partial packet, in flight in either direction, is discarded without a trace.
- RECV:
  - `in_ready`=1.
  - Each handshake (`in_valid & in_ready`) writes the flit to `buf[wr_ptr]` and increments `wr_ptr`.
  - Handshake with `in_last`=1: latch length = `wr_ptr`+1, go to SEND.
  - Handshake at `wr_ptr`=MAX_PKT_LEN-1 with `in_last`=0: go to DROP. Buffer contents are invalidated.
- DROP:
  - `in_ready`=1; all accepted flits are discarded.
  - Handshake with `in_last`=1: increment `drop_count`, reset `wr_ptr`, go to RECV.
- SEND:
  - `in_ready`=0; `out_valid`=1.
  - `out_flit`=`buf[rd_ptr]`, with header rewrite applied when `rd_ptr`=0.
  - `out_last`=(`rd_ptr`==length-1).
  - Each handshake increments `rd_ptr`.
  - Handshake on the last flit: increment `pkt_count`, clear pointers, go to RECV.
- Header rewrite: the source field sits at [FLIT_WIDTH-DEST_WIDTH-CLASS_WIDTH-1 -: DEST_WIDTH].
  - It is exchanged with the destination field.
  - The class field and the remaining low bits pass unchanged.
  - Payload flits are never modified.
- Single-flit packet: the header is both first and last flit, so rewrite and `out_last` apply together.
- Counters wrap from 0xFFFF to 0x0000.

## Timing
- `in_ready`, `out_valid`, `out_last` and the state are registered. `out_flit` is a combinational read of the buffer at `rd_ptr`.
- Latency: `out_valid` rises in the cycle after the `in_last` handshake. The first output flit appears one cycle after the last input flit.
- `in_ready` rises in the cycle after the final output handshake.
- Throughput: a packet of L flits occupies the block for at least 2L cycles (half-duplex).
- Output holds: while `out_valid`=1 and `out_ready`=0, `out_flit` and `out_last` are held stable.
- Output obeys valid/ready: `out_valid` never drops before a handshake.
- Input: `in_valid` may toggle freely. Only cycles where both `in_valid` and `in_ready` are high transfer a flit.

## Configuration
- `NOC_LOOPBACK_SWAP_EN`:
  - Defined: header destination/source swap as above.
  - Undefined: the header passes unmodified. The swap logic is not compiled; all other behaviour is identical.

## Test plan
- Basic packet (FLIT_WIDTH=32, swap on): send 3 flits `0x0A10_1234`, `0xDEAD_BEEF`, `0x0000_0001` (last) -> output `0x1208_1234`, `0xDEAD_BEEF`, `0x0000_0001`. `out_last` only on the third flit; first `out_valid` one cycle after the input last; `pkt_count`=1.
- Backpressure: hold `out_ready`=0 for 5 cycles during SEND -> `out_valid`=1 and `out_flit` stable; `in_ready`=0 throughout; no flit lost or duplicated.
- Single-flit packet: `0x0A10_0000` with `in_last`=1 -> one output `0x1208_0000` with `out_last`=1; `in_ready` returns to 1 the cycle after its handshake.
- Oversize (MAX_PKT_LEN=8): 10-flit packet -> no `out_valid`, `drop_count`=1. A following 2-flit packet is replayed correctly and `pkt_count` increments.
- Reset mid-SEND: assert `rst` after 1 of 3 flits has been sent -> next cycle `out_valid`=0, `in_ready`=0, counters 0. After release, a new packet replays cleanly.
- Macro undefined: the basic packet returns with header `0x0A10_1234` unchanged.
